// File: rtl/grf_wb_arbiter.sv
// Merges a never-stalled primary writeback and a FIFO-buffered secondary source onto the single GRF write port.
// Optional forwarding lookup is compiled in when GRF_WB_FWD_EN is defined.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pri_valid,
    input  logic [AW-1:0]              pri_addr,
    input  logic [DW-1:0]              pri_data,
    input  logic [DW-1:0]              pri_pc,
    input  logic                       sec_valid,
    output logic                       sec_ready,
    input  logic [AW-1:0]              sec_addr,
    input  logic [DW-1:0]              sec_data,
    input  logic [DW-1:0]              sec_pc,
    output logic                       wb_we,
    output logic [AW-1:0]              wb_waddr,
    output logic [DW-1:0]              wb_wdata,
    output logic [DW-1:0]              wb_iaddr,
`ifdef GRF_WB_FWD_EN
    input  logic [AW-1:0]              fwd_addr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] pc;
    } ent_t;

    logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sec_ready_q, sec_ready_d;
    logic             idle_q, idle_d;
    logic             wb_we_q, wb_we_d;
    logic [AW-1:0]    wb_waddr_q, wb_waddr_d;
    logic [DW-1:0]    wb_wdata_q, wb_wdata_d;
    logic [DW-1:0]    wb_iaddr_q, wb_iaddr_d;

    logic pri_issue, push, pop;

    // Issue selection, kill of stale buffered results, FIFO bookkeeping
    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_d       = ent_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        wb_we_d     = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        wb_iaddr_d  = wb_iaddr_q;

        pri_issue = pri_valid && (pri_addr != '0);
        push      = sec_valid && sec_ready_q && (sec_addr != '0);
        pop       = !pri_issue && (count_q != '0);

        if (pri_issue) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = pri_addr;
            wb_wdata_d = pri_data;
            wb_iaddr_d = pri_pc;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_q[i].addr == pri_addr) ent_valid_d[i] = 1'b0;
            end
        end else if (pop) begin
            if (ent_valid_q[rd_ptr_q]) begin
                wb_we_d    = 1'b1;
                wb_waddr_d = ent_q[rd_ptr_q].addr;
                wb_wdata_d = ent_q[rd_ptr_q].data;
                wb_iaddr_d = ent_q[rd_ptr_q].pc;
            end
            ent_valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = PW'(rd_ptr_q + 1'b1);
        end

        // Same-cycle push is younger than the primary, so it is written after the kill
        if (push) begin
            ent_valid_d[wr_ptr_q] = 1'b1;
            ent_d[wr_ptr_q]       = '{addr: sec_addr, data: sec_data, pc: sec_pc};
            wr_ptr_d = PW'(wr_ptr_q + 1'b1);
        end

        count_d     = CW'(count_q + CW'(push) - CW'(pop));
        sec_ready_d = (count_d < CW'(DEPTH));
        idle_d      = (count_d == '0) && !wb_we_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid_q <= '0;
            ent_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            sec_ready_q <= 1'b1;
            idle_q      <= 1'b1;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            wb_iaddr_q  <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_q       <= ent_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            sec_ready_q <= sec_ready_d;
            idle_q      <= idle_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_iaddr_q  <= wb_iaddr_d;
        end
    end

    assign sec_ready  = sec_ready_q;
    assign idle       = idle_q;
    assign fifo_count = count_q;
    assign wb_we      = wb_we_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_iaddr   = wb_iaddr_q;

`ifdef GRF_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest valid FIFO match wins over the output register
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_addr != '0) begin
            if (wb_we_q && (wb_waddr_q == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_wdata_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                fwd_idx = PW'(rd_ptr_q + PW'(i));
                if (ent_valid_q[fwd_idx] && (ent_q[fwd_idx].addr == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_q[fwd_idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed-vector bench for grf_wb_arbiter; forwarding checks build only with GRF_WB_FWD_EN.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pri_valid;
    logic [4:0]  pri_addr;
    logic [31:0] pri_data, pri_pc;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data, sec_pc;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, wb_iaddr;
    logic [2:0]  fifo_count;
    logic        idle;
`ifdef GRF_WB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pri_valid  (pri_valid),
        .pri_addr   (pri_addr),
        .pri_data   (pri_data),
        .pri_pc     (pri_pc),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_addr   (sec_addr),
        .sec_data   (sec_data),
        .sec_pc     (sec_pc),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_iaddr   (wb_iaddr),
`ifdef GRF_WB_FWD_EN
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
`endif
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] pc);
        check({tag, "_we"},    32'(wb_we),    32'(we));
        check({tag, "_waddr"}, 32'(wb_waddr), 32'(a));
        check({tag, "_wdata"}, wb_wdata,      d);
        check({tag, "_iaddr"}, wb_iaddr,      pc);
    endtask

    initial begin
        reset = 1'b1;
        pri_valid = 1'b0; pri_addr = '0; pri_data = '0; pri_pc = '0;
        sec_valid = 1'b0; sec_addr = '0; sec_data = '0; sec_pc = '0;
`ifdef GRF_WB_FWD_EN
        fwd_addr = '0;
`endif
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check_wb("rst", 1'b0, 5'd0, 32'h0, 32'h0);
        check("rst_ready", 32'(sec_ready),  32'd1);
        check("rst_idle",  32'(idle),       32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);

        // Primary single write, then hold
        pri_valid = 1'b1; pri_addr = 5'd5; pri_data = 32'h1234; pri_pc = 32'h3000;
        tick();
        pri_valid = 1'b0;
        check_wb("pri", 1'b1, 5'd5, 32'h1234, 32'h3000);
        check("pri_idle", 32'(idle), 32'd0);
        tick();
        check_wb("pri_hold", 1'b0, 5'd5, 32'h1234, 32'h3000);
        check("pri_hold_idle", 32'(idle), 32'd1);

        // Primary traffic fills the FIFO with four secondary results
        for (int k = 0; k < 4; k++) begin
            pri_valid = 1'b1; pri_addr = 5'(k + 1); pri_data = 32'h100 + 32'(k); pri_pc = 32'h800 + 32'(k);
            sec_valid = 1'b1; sec_addr = 5'(k + 10); sec_data = 32'h200 + 32'(k); sec_pc = 32'h400 + 32'(k);
            tick();
            check_wb("fill", 1'b1, 5'(k + 1), 32'h100 + 32'(k), 32'h800 + 32'(k));
            check("fill_count", 32'(fifo_count), 32'(k + 1));
        end
        check("full_ready", 32'(sec_ready), 32'd0);
        // Full: secondary offer must not be taken
        pri_addr = 5'd20; pri_data = 32'h5555; pri_pc = 32'h900;
        sec_addr = 5'd21; sec_data = 32'hDEAD; sec_pc = 32'hBEEF;
        tick();
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready2", 32'(sec_ready), 32'd0);
        pri_valid = 1'b0; sec_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_wb("drain", 1'b1, 5'(k + 10), 32'h200 + 32'(k), 32'h400 + 32'(k));
            check("drain_count", 32'(fifo_count), 32'(3 - k));
        end
        check("drain_ready", 32'(sec_ready), 32'd1);
        tick();
        check("drain_we_off", 32'(wb_we), 32'd0);
        check("drain_idle",   32'(idle),  32'd1);

        // Younger primary kills older buffered write to same register
        sec_valid = 1'b1; sec_addr = 5'd8; sec_data = 32'hAAAA; sec_pc = 32'h500;
        tick();
        sec_valid = 1'b0;
        check("kill_push_count", 32'(fifo_count), 32'd1);
        check("kill_push_we",    32'(wb_we),      32'd0);
        pri_valid = 1'b1; pri_addr = 5'd8; pri_data = 32'hBBBB; pri_pc = 32'h600;
        tick();
        pri_valid = 1'b0;
        check_wb("kill_pri", 1'b1, 5'd8, 32'hBBBB, 32'h600);
        check("kill_count1", 32'(fifo_count), 32'd1);
        tick();
        check_wb("kill_pop", 1'b0, 5'd8, 32'hBBBB, 32'h600);
        check("kill_count0", 32'(fifo_count), 32'd0);
        check("kill_idle",   32'(idle),       32'd1);

        // Uncontested secondary: two-cycle latency
        sec_valid = 1'b1; sec_addr = 5'd7; sec_data = 32'h77; sec_pc = 32'h700;
        tick();
        sec_valid = 1'b0;
        check("lat_we_early", 32'(wb_we), 32'd0);
        tick();
        check_wb("lat", 1'b1, 5'd7, 32'h77, 32'h700);
        check("lat_count", 32'(fifo_count), 32'd0);
        tick();

        // Secondary to r0 completes handshake without a write
        sec_valid = 1'b1; sec_addr = 5'd0; sec_data = 32'h99; sec_pc = 32'h990;
        check("r0_ready", 32'(sec_ready), 32'd1);
        tick();
        sec_valid = 1'b0;
        check("r0_count", 32'(fifo_count), 32'd0);
        check("r0_we",    32'(wb_we),      32'd0);
        tick();
        check("r0_we2",   32'(wb_we),      32'd0);

        // Primary to r0 is ignored
        pri_valid = 1'b1; pri_addr = 5'd0; pri_data = 32'h42; pri_pc = 32'h420;
        tick();
        pri_valid = 1'b0;
        check_wb("pri_r0", 1'b0, 5'd7, 32'h77, 32'h700);

`ifdef GRF_WB_FWD_EN
        // Forwarding: two buffered writes to r9, youngest data wins
        pri_valid = 1'b1; pri_addr = 5'd1; pri_data = 32'h1; pri_pc = 32'h10;
        sec_valid = 1'b1; sec_addr = 5'd9; sec_data = 32'h11; sec_pc = 32'hA0;
        tick();
        sec_data = 32'h22; sec_pc = 32'hA4;
        tick();
        sec_valid = 1'b0;
        fwd_addr = 5'd9;
        #1;
        check("fwd_hit9",  32'(fwd_hit), 32'd1);
        check("fwd_data9", fwd_data,     32'h22);
        fwd_addr = 5'd1;
        #1;
        check("fwd_hit1",  32'(fwd_hit), 32'd1);
        check("fwd_data1", fwd_data,     32'h1);
        fwd_addr = 5'd0;
        #1;
        check("fwd_hit0",  32'(fwd_hit), 32'd0);
        check("fwd_data0", fwd_data,     32'h0);
        fwd_addr = 5'd3;
        #1;
        check("fwd_miss",  32'(fwd_hit), 32'd0);
        pri_valid = 1'b0;
        fwd_addr = 5'd0;
        tick(); tick(); tick();
        check("fwd_drain_count", 32'(fifo_count), 32'd0);
`endif

        // Reset with three entries pending discards them
        for (int k = 0; k < 3; k++) begin
            pri_valid = 1'b1; pri_addr = 5'd1; pri_data = 32'h31; pri_pc = 32'h310;
            sec_valid = 1'b1; sec_addr = 5'(k + 14); sec_data = 32'h300 + 32'(k); sec_pc = 32'h330;
            tick();
        end
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        pri_valid = 1'b0; sec_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_wb("mid_rst", 1'b0, 5'd0, 32'h0, 32'h0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ready", 32'(sec_ready),  32'd1);
        check("mid_rst_idle",  32'(idle),       32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_we", 32'(wb_we), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
